// File: rtl/tinker_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses, flushes on redirect.
// Optional statistics counters are enabled by defining TINKER_FETCH_QUEUE_STATS_EN.
module tinker_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
`ifdef TINKER_FETCH_QUEUE_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushes,
`endif
    input  logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            resp_pc_q, resp_pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          outst_q, outst_d;
    logic [CW-1:0]          drop_q, drop_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][31:0] instr_q;
    logic [DEPTH-1:0][31:0] pc_q;

    logic       req_fire, resp_ok, push, pop;
    logic [CW:0] inflight;

    // Credit check covers both queued and in-flight entries so responses never overflow.
    assign inflight      = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_valid = reset && !redirect_valid && (inflight < DEPTH_W);
    assign mem_req_addr  = fetch_pc_q;
    assign out_valid     = (count_q != '0) && !redirect_valid;
    assign out_instr     = instr_q[rd_ptr_q];
    assign out_pc        = pc_q[rd_ptr_q];

    assign req_fire = mem_req_valid && mem_req_ready;
    assign resp_ok  = mem_resp_valid && (outst_q != '0);
    assign push     = resp_ok && (drop_q == '0) && !redirect_valid;
    assign pop      = out_valid && out_ready;

    always_comb begin
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_ok);
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = outst_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                instr_q[wr_ptr_q] <= mem_resp_data;
                pc_q[wr_ptr_q]    <= resp_pc_q;
            end
        end
    end

`ifdef TINKER_FETCH_QUEUE_STATS_EN
    logic [31:0] stat_fetched_q, stat_flushes_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_q + 32'(push);
            stat_flushes_q <= stat_flushes_q + 32'(redirect_valid);
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for tinker_fetch_queue: one task per scenario, in-order 1-cycle memory model.
module tb_tinker_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef TINKER_FETCH_QUEUE_STATS_EN
    logic [31:0] stat_fetched, stat_flushes;
`endif

    int errs = 0;
    int checks = 0;
    int hs_count = 0;
    bit resp_en = 1'b0;
    logic [31:0] pend[$];

    always #5 clk = ~clk;

    tinker_fetch_queue #(.DEPTH(4), .RESET_PC(32'h2000)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid),
`ifdef TINKER_FETCH_QUEUE_STATS_EN
        .stat_fetched(stat_fetched), .stat_flushes(stat_flushes),
`endif
        .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    // One clock: record handshake, cross the edge, then the memory answers the oldest request.
    task automatic step();
        #1;
        if (mem_req_valid && mem_req_ready) begin
            pend.push_back(mem_req_addr);
            hs_count++;
        end
        @(posedge clk);
        #1;
        if (resp_en && pend.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = instr_of(pend.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        resp_en = 1'b0; pend.delete(); hs_count = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got=%0h exp=0", mem_req_valid); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errs++; $display("FAIL rst_out_instr got=%08h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errs++; $display("FAIL rst_out_pc got=%08h exp=0", out_pc); end
        checks++; if (mem_req_addr !== 32'h2000) begin errs++; $display("FAIL rst_addr got=%08h exp=00002000", mem_req_addr); end
`ifdef TINKER_FETCH_QUEUE_STATS_EN
        checks++; if (stat_fetched !== 32'h0 || stat_flushes !== 32'h0) begin errs++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_fetched, stat_flushes); end
`endif
        reset = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
            errs++; $display("FAIL first_req got=%0h/%08h exp=1/00002000", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_req_ready = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 + 32'(4*k)) begin
                errs++; $display("FAIL stream_addr%0d got=%0h/%08h exp=1/%08h", k, mem_req_valid, mem_req_addr, 32'h2000 + 32'(4*k)); end
            if (k >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2000 + 32'(4*(k-2)) || out_instr !== 32'h1000_2000 + 32'(4*(k-2))) begin
                    errs++; $display("FAIL stream_out%0d got=%0h/%08h/%08h exp=1/%08h/%08h", k, out_valid, out_pc, out_instr,
                                     32'h2000 + 32'(4*(k-2)), 32'h1000_2000 + 32'(4*(k-2))); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_early%0d got=%0h exp=0", k, out_valid); end
            end
            step();
        end
`ifdef TINKER_FETCH_QUEUE_STATS_EN
        checks++; if (stat_fetched !== 32'd5 || stat_flushes !== 32'd0) begin errs++; $display("FAIL stream_stats got=%0d/%0d exp=5/0", stat_fetched, stat_flushes); end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b1;
        repeat (10) step();
        checks++; if (hs_count !== 4) begin errs++; $display("FAIL bp_reqs got=%0d exp=4", hs_count); end
        checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h2000) begin
            errs++; $display("FAIL bp_full got=%0h/%0h/%08h exp=0/1/00002000", mem_req_valid, out_valid, out_pc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2010 || out_pc !== 32'h2004) begin
            errs++; $display("FAIL bp_one_slot got=%0h/%08h/%08h exp=1/00002010/00002004", mem_req_valid, mem_req_addr, out_pc); end
        step();
        checks++; if (hs_count !== 5) begin errs++; $display("FAIL bp_refill got=%0d exp=5", hs_count); end
        redirect_valid = 1'b1; redirect_pc = 32'h4000;
        #1;
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errs++; $display("FAIL bp_redir_mask got=%0h/%0h exp=0/0", out_valid, mem_req_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || mem_req_addr !== 32'h4000) begin
            errs++; $display("FAIL bp_flush got=%0h/%08h exp=0/00004000", out_valid, mem_req_addr); end
    endtask

    task automatic test_redirect();
        int n;
        apply_reset();
        mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000) begin
            errs++; $display("FAIL redir_addr got=%0h/%08h exp=1/00003000", mem_req_valid, mem_req_addr); end
        resp_en = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (n !== 5) begin errs++; $display("FAIL redir_latency got=%0d exp=5", n); end
        checks++; if (out_pc !== 32'h3000 || out_instr !== 32'h1000_3000) begin
            errs++; $display("FAIL redir_head got=%08h/%08h exp=00003000/10003000", out_pc, out_instr); end
    endtask

    task automatic test_redirect_resp();
        int n;
        apply_reset();
        mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b0;
        repeat (2) step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = instr_of(pend.pop_front());
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        step();
        redirect_valid = 1'b0; mem_req_ready = 1'b1; resp_en = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (n !== 3) begin errs++; $display("FAIL rr_latency got=%0d exp=3", n); end
        checks++; if (out_pc !== 32'h3000 || out_instr !== 32'h1000_3000) begin
            errs++; $display("FAIL rr_head got=%08h/%08h exp=00003000/10003000", out_pc, out_instr); end
`ifdef TINKER_FETCH_QUEUE_STATS_EN
        checks++; if (stat_fetched !== 32'd1 || stat_flushes !== 32'd1) begin errs++; $display("FAIL rr_stats got=%0d/%0d exp=1/1", stat_fetched, stat_flushes); end
`endif
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_req_ready = 1'b0; out_ready = 1'b0; resp_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        checks++; if (mem_req_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_start got=%08h exp=fffffffc", mem_req_addr); end
        step();
        checks++; if (mem_req_addr !== 32'h0) begin errs++; $display("FAIL wrap_addr got=%08h exp=00000000", mem_req_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
            errs++; $display("FAIL wrap_head got=%0h/%08h exp=1/fffffffc", out_valid, out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
            errs++; $display("FAIL wrap_next got=%0h/%08h/%08h exp=1/00000000/10000000", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_spurious();
        apply_reset();
        mem_req_ready = 1'b0; out_ready = 1'b0; resp_en = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        step();
        checks++; if (out_valid !== 1'b0 || mem_req_addr !== 32'h2000) begin
            errs++; $display("FAIL spurious got=%0h/%08h exp=0/00002000", out_valid, mem_req_addr); end
        mem_req_ready = 1'b1; resp_en = 1'b1;
        repeat (2) step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2000 || out_instr !== 32'h1000_2000) begin
            errs++; $display("FAIL spurious_after got=%0h/%08h/%08h exp=1/00002000/10002000", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_midreset();
        apply_reset();
        mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b1;
        repeat (5) step();
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL mr_filled got=%0h exp=1", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || mem_req_addr !== 32'h2000) begin
            errs++; $display("FAIL mr_in_reset got=%0h/%0h/%08h/%08h/%08h exp=0/0/0/0/00002000",
                             mem_req_valid, out_valid, out_instr, out_pc, mem_req_addr); end
`ifdef TINKER_FETCH_QUEUE_STATS_EN
        checks++; if (stat_fetched !== 32'h0 || stat_flushes !== 32'h0) begin errs++; $display("FAIL mr_stats got=%0d/%0d exp=0/0", stat_fetched, stat_flushes); end
`endif
        mem_resp_valid = 1'b0; resp_en = 1'b0; pend.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL mr_release got=%0h/%08h/%0h exp=1/00002000/0", mem_req_valid, mem_req_addr, out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_resp();
        test_wrap();
        test_spurious();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
